// File: rtl/div_sqrt_iter_pkg.sv
// rtl/div_sqrt_iter_pkg.sv - shared types, defaults and width helpers for div_sqrt_iter_core
// Contents: FSM state enum, default parameter values, operand/result width functions.
package div_sqrt_iter_pkg;

    localparam int unsigned C_MANT_DEF = 23;
    localparam int unsigned C_ITER_DEF = 1;
    localparam int unsigned C_PC_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Operand/result width: hidden bit, one integer bit for the [1,4) radicand, C_MANT fraction bits.
    function automatic int unsigned calc_w(input int unsigned mant);
        return mant + 2;
    endfunction

    // Number of quotient/root digits produced by the recurrence.
    function automatic int unsigned calc_n(input int unsigned mant);
        return mant + 2;
    endfunction

endpackage

// File: rtl/div_sqrt_iter_step.sv
// rtl/div_sqrt_iter_step.sv - one combinational radix-2 non-restoring divide/sqrt step
// Ports: rem_i/rem_o partial remainder (W+2 bits, two's complement), root_i/root_o partial
// quotient/root, div_i divisor, rad_i next radicand bit pair, sqrt_i mode, prev_i previous
// digit (selects add or subtract), en_i step enable (disabled steps pass everything through),
// digit_o new digit.
module div_sqrt_iter_step
    import div_sqrt_iter_pkg::*;
#(
    parameter int unsigned W = calc_w(C_MANT_DEF)
) (
    input  logic [W+1:0] rem_i,
    input  logic [W-1:0] root_i,
    input  logic [W-1:0] div_i,
    input  logic [1:0]   rad_i,
    input  logic         sqrt_i,
    input  logic         prev_i,
    input  logic         en_i,
    output logic [W+1:0] rem_o,
    output logic [W-1:0] root_o,
    output logic         digit_o
);

    localparam int unsigned RW = W + 2;

    logic [RW-1:0] base;
    logic [RW-1:0] opnd;
    logic [RW-1:0] trial;

    always_comb begin
        base    = '0;
        opnd    = '0;
        trial   = '0;
        rem_o   = rem_i;
        root_o  = root_i;
        digit_o = prev_i;

        if (sqrt_i) begin
            // 4R + next radicand pair, against 4Q+1 (subtract) or 4Q+3 (add)
            base = {rem_i[RW-3:0], rad_i};
            opnd = {root_i, ~prev_i, 1'b1};
        end else begin
            base = rem_i;
            opnd = {2'b00, div_i};
        end

        trial = prev_i ? (base - opnd) : (base + opnd);

        if (en_i) begin
            digit_o = ~trial[RW-1];
            root_o  = {root_i[W-2:0], ~trial[RW-1]};
            // Division shifts after the add/sub; sqrt already shifted via 4R above.
            rem_o   = sqrt_i ? trial : {trial[RW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sqrt_iter_core.sv
// rtl/div_sqrt_iter_core.sv - multi-cycle mantissa divide / square-root engine (radix-2 non-restoring)
// Ports: Clk_CI clock, Rst_RI async active-high reset, Div_start_SI / Sqrt_start_SI one-cycle
// starts (divide wins if both), Kill_SI abort, A_DI dividend/radicand, B_DI divisor,
// Ready_SO idle, Done_SO one-cycle result strobe, Result_DO truncated quotient/root,
// Sticky_SO final remainder nonzero.
// Optional: DIV_SQRT_PREC_CTL_EN adds Precision_ctl_SI (digits = P+1, 0 = full precision).
module div_sqrt_iter_core
    import div_sqrt_iter_pkg::*;
#(
    parameter int unsigned C_MANT           = C_MANT_DEF,
    parameter int unsigned C_ITER_PER_CYCLE = C_ITER_DEF,
    parameter int unsigned C_PC             = C_PC_DEF
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Div_start_SI,
    input  logic              Sqrt_start_SI,
    input  logic              Kill_SI,
`ifdef DIV_SQRT_PREC_CTL_EN
    input  logic [C_PC-1:0]   Precision_ctl_SI,
`endif
    input  logic [C_MANT+1:0] A_DI,
    input  logic [C_MANT+1:0] B_DI,
    output logic              Ready_SO,
    output logic              Done_SO,
    output logic [C_MANT+1:0] Result_DO,
    output logic              Sticky_SO
);

    localparam int unsigned W  = calc_w(C_MANT);
    localparam int unsigned N  = calc_n(C_MANT);
    localparam int unsigned RW = W + 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned C  = C_ITER_PER_CYCLE;

    state_e        state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [W-1:0]  root_q, root_d;
    logic [W-1:0]  div_q, div_d;
    logic [W:0]    rad_q, rad_d;       // radicand bits still to be consumed, MSB pair first
    logic          dig_q, dig_d;
    logic          sqrt_q, sqrt_d;
    logic [CW-1:0] left_q, left_d;     // recurrence steps still to run
    logic [CW-1:0] shift_q, shift_d;   // result alignment when fewer than N digits are computed
    logic [W-1:0]  result_q, result_d;
    logic          sticky_q, sticky_d;

    logic [C_PC-1:0] prec;
    logic [CW-1:0]   iters;
    logic [RW-1:0]   rem_fix;
    logic [W-1:0]    res_fin;
    logic            sticky_fin;

`ifdef DIV_SQRT_PREC_CTL_EN
    assign prec = Precision_ctl_SI;
`else
    assign prec = '0;
`endif

    logic [RW-1:0] rem_c  [C+1];
    logic [W-1:0]  root_c [C+1];
    logic          dig_c  [C+1];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;
    assign dig_c[0]  = dig_q;

    for (genvar k = 0; k < C; k++) begin : g_step
        // Steps beyond the remaining count (last cycle, N not a multiple of C) are masked.
        div_sqrt_iter_step #(.W(W)) u_step (
            .rem_i   (rem_c[k]),
            .root_i  (root_c[k]),
            .div_i   (div_q),
            .rad_i   (rad_q[W-2*k -: 2]),
            .sqrt_i  (sqrt_q),
            .prev_i  (dig_c[k]),
            .en_i    (left_q > CW'(k)),
            .rem_o   (rem_c[k+1]),
            .root_o  (root_c[k+1]),
            .digit_o (dig_c[k+1])
        );
    end

    always_comb begin
        iters = CW'(N);
        if (prec != '0 && (int'(prec) + 1) < int'(N)) begin
            iters = CW'(prec) + CW'(1);
        end

        // Negative final remainder: add back 2B (division, remainder kept doubled) or 2Q+1 (sqrt).
        rem_fix = rem_q;
        if (rem_q[RW-1]) begin
            rem_fix = rem_q + (sqrt_q ? {1'b0, root_q, 1'b1} : {1'b0, div_q, 1'b0});
        end
        sticky_fin = |rem_fix;
        res_fin    = root_q << shift_q;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        root_d   = root_q;
        div_d    = div_q;
        rad_d    = rad_q;
        dig_d    = dig_q;
        sqrt_d   = sqrt_q;
        left_d   = left_q;
        shift_d  = shift_q;
        result_d = result_q;
        sticky_d = sticky_q;

        case (state_q)
            IDLE: begin
                if ((Div_start_SI || Sqrt_start_SI) && !Kill_SI) begin
                    state_d = RUN;
                    sqrt_d  = !Div_start_SI;
                    rem_d   = Div_start_SI ? {2'b00, A_DI} : '0;
                    root_d  = '0;
                    div_d   = B_DI;
                    rad_d   = {A_DI, 1'b0};
                    dig_d   = 1'b1;
                    left_d  = iters;
                    shift_d = CW'(N) - iters;
                end
            end
            RUN: begin
                if (Kill_SI) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = rem_c[C];
                    root_d = root_c[C];
                    dig_d  = dig_c[C];
                    rad_d  = rad_q << (2 * C);
                    if (left_q > CW'(C)) begin
                        left_d = left_q - CW'(C);
                    end else begin
                        left_d  = '0;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!Kill_SI) begin
                    result_d = res_fin;
                    sticky_d = sticky_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            root_q   <= '0;
            div_q    <= '0;
            rad_q    <= '0;
            dig_q    <= 1'b0;
            sqrt_q   <= 1'b0;
            left_q   <= '0;
            shift_q  <= '0;
            result_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            div_q    <= div_d;
            rad_q    <= rad_d;
            dig_q    <= dig_d;
            sqrt_q   <= sqrt_d;
            left_q   <= left_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            sticky_q <= sticky_d;
        end
    end

    // Results are presented in the FIN cycle itself and held in result_q afterwards.
    assign Ready_SO  = (state_q == IDLE);
    assign Done_SO   = (state_q == FIN) && !Kill_SI;
    assign Result_DO = Done_SO ? res_fin : result_q;
    assign Sticky_SO = Done_SO ? sticky_fin : sticky_q;

endmodule

// File: tb/tb_div_sqrt_iter_core.sv
// tb/tb_div_sqrt_iter_core.sv - self-checking bench for div_sqrt_iter_core, C_ITER_PER_CYCLE 1..4
module tb_div_sqrt_iter_core;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start, sqrt_start, kill;
    logic [24:0] a, b;
    logic [4:0]  prec;

    logic [NI-1:0] ready, done, sticky;
    logic [24:0]   res [NI];

    int n_vec = 0;
    int n_bad = 0;
    int exp_lat [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        div_sqrt_iter_core #(
            .C_MANT           (23),
            .C_ITER_PER_CYCLE (g + 1),
            .C_PC             (5)
        ) u_dut (
            .Clk_CI           (clk),
            .Rst_RI           (rst),
            .Div_start_SI     (div_start),
            .Sqrt_start_SI    (sqrt_start),
            .Kill_SI          (kill),
`ifdef DIV_SQRT_PREC_CTL_EN
            .Precision_ctl_SI (prec),
`endif
            .A_DI             (a),
            .B_DI             (b),
            .Ready_SO         (ready[g]),
            .Done_SO          (done[g]),
            .Result_DO        (res[g]),
            .Sticky_SO        (sticky[g])
        );
    end

    typedef struct {
        string       name;
        logic        sq;
        logic        both;
        logic        glitch;
        logic [24:0] a;
        logic [24:0] b;
        logic [24:0] res;
        logic        st;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[c%0d]: got %h expected %h", nm, inst + 1, act, expv);
        end
    endtask

    task automatic run_op(input string nm, input logic sq, input logic both, input logic glitch,
                          input logic [24:0] ta, input logic [24:0] tb_v,
                          input logic [24:0] er, input logic es);
        int          lat   [NI];
        logic [24:0] got_r [NI];
        logic        got_s [NI];
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0; got_r[i] = '0; got_s[i] = 1'b0;
        end
        @(negedge clk);
        a = ta; b = tb_v;
        div_start  = !sq || both;
        sqrt_start = sq || both;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (lat[i] == 0 && done[i]) begin
                    lat[i] = cyc; got_r[i] = res[i]; got_s[i] = sticky[i];
                end else if (lat[i] != 0 && cyc == lat[i] + 1) begin
                    check({nm, "_done_pulse"}, i, 32'(done[i]), 32'd0);
                end
            end
            if (cyc == 1) check({nm, "_busy"}, 0, 32'(ready), 32'h0);
            @(negedge clk);
            if (cyc == 1) begin
                div_start = 1'b0; sqrt_start = 1'b0;
                a = ~ta; b = 25'h1555555;
            end
            if (glitch) begin
                div_start  = (cyc == 3);
                sqrt_start = (cyc == 3);
            end
        end
        for (int i = 0; i < NI; i++) begin
            check({nm, "_latency"}, i, 32'(lat[i]), 32'(exp_lat[i]));
            check({nm, "_result"}, i, 32'(got_r[i]), 32'(er));
            check({nm, "_sticky"}, i, 32'(got_s[i]), 32'(es));
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
        a = '0; b = '0; prec = '0;
        exp_lat = '{26, 14, 10, 8};

        vecs.push_back('{"div_1p5_1",     1'b0, 1'b0, 1'b0, 25'h0C00000, 25'h0800000, 25'h1800000, 1'b0});
        vecs.push_back('{"div_1_1p5",     1'b0, 1'b0, 1'b0, 25'h0800000, 25'h0C00000, 25'h0AAAAAA, 1'b1});
        vecs.push_back('{"sqrt_1",        1'b1, 1'b0, 1'b0, 25'h0800000, 25'h0000000, 25'h1000000, 1'b0});
        vecs.push_back('{"sqrt_2",        1'b1, 1'b0, 1'b0, 25'h1000000, 25'h0000000, 25'h16A09E6, 1'b1});
        vecs.push_back('{"div_1_1",       1'b0, 1'b0, 1'b0, 25'h0800000, 25'h0800000, 25'h1000000, 1'b0});
        vecs.push_back('{"div_max_1",     1'b0, 1'b0, 1'b0, 25'h0FFFFFF, 25'h0800000, 25'h1FFFFFE, 1'b0});
        vecs.push_back('{"sqrt_max",      1'b1, 1'b0, 1'b0, 25'h1FFFFFF, 25'h0000000, 25'h1FFFFFF, 1'b1});
        vecs.push_back('{"sqrt_2p25",     1'b1, 1'b0, 1'b0, 25'h1200000, 25'h0000000, 25'h1800000, 1'b0});
        vecs.push_back('{"both_starts",   1'b0, 1'b1, 1'b0, 25'h0C00000, 25'h0800000, 25'h1800000, 1'b0});
        vecs.push_back('{"run_starts",    1'b0, 1'b0, 1'b1, 25'h0800000, 25'h0C00000, 25'h0AAAAAA, 1'b1});
        vecs.push_back('{"div_1p5_1p5",   1'b0, 1'b0, 1'b0, 25'h0C00000, 25'h0C00000, 25'h1000000, 1'b0});

        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_ready", i, 32'(ready[i]), 32'd1);
            check("reset_done", i, 32'(done[i]), 32'd0);
            check("reset_result", i, 32'(res[i]), 32'd0);
            check("reset_sticky", i, 32'(sticky[i]), 32'd0);
        end
        rst = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            run_op(vecs[v].name, vecs[v].sq, vecs[v].both, vecs[v].glitch,
                   vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].st);
        end

        // Kill during RUN: no Done, idle next cycle, previous result (1.5/1.5 = 1.0) kept.
        seen = 0;
        @(negedge clk);
        a = 25'h0800000; b = 25'h0C00000; div_start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            seen += int'($countones(done));
            if (cyc == 6) check("kill_ready", 0, 32'(ready), 32'hF);
            @(negedge clk);
            div_start = 1'b0;
            kill = (cyc == 5);
        end
        check("kill_no_done", 0, 32'(seen), 32'd0);
        for (int i = 0; i < NI; i++) begin
            check("kill_hold_result", i, 32'(res[i]), 32'h1000000);
            check("kill_hold_sticky", i, 32'(sticky[i]), 32'd0);
        end
        run_op("after_kill", 1'b1, 1'b0, 1'b0, 25'h1000000, 25'h0, 25'h16A09E6, 1'b1);

        // Reset in the middle of RUN takes effect immediately.
        @(negedge clk);
        a = 25'h0800000; b = 25'h0C00000; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("midrst_ready", i, 32'(ready[i]), 32'd1);
            check("midrst_done", i, 32'(done[i]), 32'd0);
            check("midrst_result", i, 32'(res[i]), 32'd0);
            check("midrst_sticky", i, 32'(sticky[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset", 1'b0, 1'b0, 1'b0, 25'h0C00000, 25'h0800000, 25'h1800000, 1'b0);

`ifdef DIV_SQRT_PREC_CTL_EN
        prec = 5'd7;
        exp_lat = '{9, 5, 4, 3};
        run_op("prec7_div", 1'b0, 1'b0, 1'b0, 25'h0800000, 25'h0C00000, 25'h0AA0000, 1'b1);
        prec = 5'd0;
        exp_lat = '{26, 14, 10, 8};
        run_op("prec0_div", 1'b0, 1'b0, 1'b0, 25'h0800000, 25'h0C00000, 25'h0AAAAAA, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
